dco_array: RTL
==============

Name: dco_array

Overview:
- Multi-channel digitally controlled oscillator; next generation of the single-channel tile DCO.
- Generates CHANNELS independent square waves from one system clock via a shared prescaler tick.
- Each channel has its own frequency code, mapping mode (priority-encoded or direct) and enable.
- Half-period changes take effect only at toggle boundaries, so no output pulse is ever shortened by a code change.

Parameters:
CHANNELS, 2, number of independent oscillator channels (1..8)
CODE_W, 8, width of each channel's frequency code
CNT_W, 8, width of half-period register and counter
DIV, 5, prescaler ratio: one tick every DIV clk cycles (DIV>=1; 1 = every cycle)
DEFAULT_HP, 50, half-period used after reset and for code==0 in mode 0

Ports:
clk  input  1  system clock
resetnn  input  1  reset, asynchronous, active-low
en  input  CHANNELS  per-channel run enable
mode  input  CHANNELS  per-channel mapping: 0 = priority-encoded, 1 = direct
code  input  CHANNELS*CODE_W  packed codes; channel n at [n*CODE_W +: CODE_W]
dco_out  output  CHANNELS  oscillator outputs
toggle_p  output  CHANNELS  one-clk pulse in the cycle dco_out[n] changes
tick  output  1  prescaler tick, one clk wide

Behaviour:
- Reset (resetnn=0, asynchronous): prescaler=0, tick=0, dco_out=0, toggle_p=0, all counters=0, all hp=DEFAULT_HP.
- Prescaler: counts 0..DIV-1 every clk. tick=1 in the cycle the count equals DIV-1, then the count wraps to 0. With DIV=1, tick is constantly 1 after reset.
- Per-channel step: evaluated on clk when tick=1 and en[n]=1.
  - If cnt==hp: dco_out toggles, cnt<=0, hp<=next_hp(n), toggle_p=1 for that clk.
  - Else: cnt<=cnt+1, toggle_p=0.
- Each half-period is therefore hp+1 ticks. A full output period is 2*(hp+1) ticks.
- en[n]=0: cnt, hp and dco_out hold. toggle_p=0. On re-enable, counting resumes from the held cnt. No reset of phase.
- next_hp, mode 0:
  - i = index of the most-significant 1 in code (CODE_W-1 is the top bit). hp = i+3.
  - For CODE_W=8 this gives MSB set -> 10, down to only bit0 set -> 3.
  - code==0 -> DEFAULT_HP.
- next_hp, mode 1:
  - hp = code, zero-extended or truncated to CNT_W.
  - code==0 is clamped to 1, so the minimum half-period is 2 ticks.
- Sampling rule: code and mode are sampled combinationally only in the toggle cycle. Changes at any other time have no effect until the next boundary.
- After reset, the first half-period always uses DEFAULT_HP, regardless of code.
- Widths: all arithmetic is unsigned. cnt never exceeds hp, so there is no wrap-around.
- Elaboration errors:
  - DEFAULT_HP must fit in CNT_W.
  - CODE_W+2 must fit in CNT_W.
- Channel independence: channels share only tick. Simultaneous toggles on several channels are legal and independent.
- Reset mid-operation: outputs go to 0 immediately. The first toggle after release occurs DEFAULT_HP+1 ticks later.

Decomposition:
- Package dco_pkg holds:
  - function prio_hp(code, default_hp) returning the mode-0 half-period;
  - localparam MODE_PRIO=0, MODE_DIRECT=1;
  - minimum half-period constant HP_MIN=1.
- Sub-module dco_channel contains one channel (cnt, hp, dco_out, toggle_p). The top instantiates CHANNELS copies with a generate loop.
- The prescaler lives in the top.

Test Plan:
- DIV=1, ch0 mode0 code=8'h80 en=1, from reset:
  - first toggle at tick 51 (DEFAULT_HP+1);
  - thereafter toggles every 11 clk (period 22), toggle_p aligned with each edge.
- DIV=5, ch1 mode1 code=8'd3:
  - tick every 5 clk;
  - after the first default half-period, dco_out toggles every 20 clk.
- Mid-half-period change (mode0, code 8'h01 -> 8'h80 at cnt=2):
  - current half-period still ends at hp=3 (4 ticks);
  - next half-period is 11 ticks;
  - no short pulse.
- Boundary codes:
  - mode0 code=0 keeps hp=50;
  - mode1 code=0 gives half-period 2 ticks;
  - mode1 code=8'hFF gives 256 ticks.
- en[0] dropped for 7 clk mid-count:
  - cnt and dco_out frozen, toggle_p=0;
  - toggle occurs exactly 7 clk late, ch1 unaffected.
- Assert resetnn=0 asynchronously between clk edges while dco_out=1:
  - dco_out, toggle_p and tick go 0 at once;
  - after release, first toggle at tick DEFAULT_HP+1.

Source files
------------

// File: rtl/dco_pkg.sv
// Shared constants and the priority-mode half-period mapping
// for the multi-channel DCO.
package dco_pkg;

    localparam int MODE_PRIO   = 0;
    localparam int MODE_DIRECT = 1;
    localparam int HP_MIN      = 1;
    localparam int CODE_MAX_W  = 32;

    // Highest set bit i maps to i+3; an all-zero code keeps the default.
    function automatic int prio_hp(
        input logic [CODE_MAX_W-1:0] code,
        input int                    default_hp
    );
        int hp;
        hp = default_hp;
        for (int i = 0; i < CODE_MAX_W; i++) begin
            if (code[i]) hp = i + 3;
        end
        return hp;
    endfunction

endpackage

// File: rtl/dco_array_if.sv
// Control and output bundle of the multi-channel DCO.
// master drives codes/enables, slave is the oscillator array.
interface dco_array_if #(
    parameter int CHANNELS = 2,
    parameter int CODE_W   = 8
);

    logic [CHANNELS-1:0]        en;
    logic [CHANNELS-1:0]        mode;
    logic [CHANNELS*CODE_W-1:0] code;
    logic [CHANNELS-1:0]        dco_out;
    logic [CHANNELS-1:0]        toggle_p;
    logic                       tick;

    modport master (
        output en,
        output mode,
        output code,
        input  dco_out,
        input  toggle_p,
        input  tick
    );

    modport slave (
        input  en,
        input  mode,
        input  code,
        output dco_out,
        output toggle_p,
        output tick
    );

endinterface

// File: rtl/dco_channel.sv
// One oscillator channel: half-period counter that reloads its
// half-period only at a toggle, so pulses are never shortened.
module dco_channel
    import dco_pkg::*;
#(
    parameter int CODE_W     = 8,
    parameter int CNT_W      = 8,
    parameter int DEFAULT_HP = 50
) (
    input  logic              clk,
    input  logic              resetnn,
    input  logic              i_tick,
    input  logic              i_en,
    input  logic              i_mode,
    input  logic [CODE_W-1:0] i_code,
    output logic              o_dco,
    output logic              o_toggle
);

    if ((DEFAULT_HP >> CNT_W) != 0 || DEFAULT_HP < 0) begin : g_bad_default
        $error("DEFAULT_HP does not fit in CNT_W");
    end
    if (((CODE_W + 2) >> CNT_W) != 0) begin : g_bad_code_w
        $error("CODE_W+2 does not fit in CNT_W");
    end
    if (CODE_W > CODE_MAX_W || CODE_W < 1) begin : g_bad_code_max
        $error("CODE_W out of supported range");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hp;
    logic             r_dco;
    logic             r_toggle;

    logic [CNT_W-1:0] w_prio_hp;
    logic [CNT_W-1:0] w_code_hp;
    logic [CNT_W-1:0] w_direct_hp;
    logic [CNT_W-1:0] w_next_hp;
    logic             w_step;
    logic             w_wrap;

    assign w_prio_hp = CNT_W'(prio_hp(CODE_MAX_W'(i_code), DEFAULT_HP));
    assign w_code_hp = CNT_W'(i_code);

    // A zero direct code would give a one-tick half-period; clamp it.
    assign w_direct_hp = (w_code_hp == '0) ? CNT_W'(HP_MIN) : w_code_hp;

    always_comb begin
        w_next_hp = w_prio_hp;
        unique case (i_mode)
            MODE_PRIO[0]:   w_next_hp = w_prio_hp;
            MODE_DIRECT[0]: w_next_hp = w_direct_hp;
        endcase
    end

    assign w_step = i_tick & i_en;
    assign w_wrap = (r_cnt == r_hp);

    always_ff @(posedge clk or negedge resetnn) begin
        if (!resetnn) begin
            r_cnt    <= '0;
            r_hp     <= CNT_W'(DEFAULT_HP);
            r_dco    <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_toggle <= w_step & w_wrap;
            if (w_step) begin
                if (w_wrap) begin
                    r_dco <= ~r_dco;
                    r_cnt <= '0;
                    r_hp  <= w_next_hp;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_dco    = r_dco;
    assign o_toggle = r_toggle;

endmodule

// File: rtl/dco_array.sv
// Multi-channel DCO: shared prescaler tick drives CHANNELS
// independent square-wave channels.
module dco_array
    import dco_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int CODE_W     = 8,
    parameter int CNT_W      = 8,
    parameter int DIV        = 5,
    parameter int DEFAULT_HP = 50
) (
    input  logic        clk,
    input  logic        resetnn,
    dco_array_if.slave  bus
);

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("CHANNELS must be 1..8");
    end
    if (DIV < 1) begin : g_bad_div
        $error("DIV must be at least 1");
    end

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]       r_pres;
    logic [PW-1:0]       w_pres_nxt;
    logic                r_tick;
    logic [CHANNELS-1:0] w_dco;
    logic [CHANNELS-1:0] w_toggle;

    always_comb begin
        w_pres_nxt = r_pres + PW'(1);
        if (r_pres == PW'(DIV - 1)) w_pres_nxt = '0;
    end

    // tick is registered so it is high exactly while r_pres==DIV-1.
    always_ff @(posedge clk or negedge resetnn) begin
        if (!resetnn) begin
            r_pres <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pres <= w_pres_nxt;
            r_tick <= (w_pres_nxt == PW'(DIV - 1));
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        dco_channel #(
            .CODE_W     (CODE_W),
            .CNT_W      (CNT_W),
            .DEFAULT_HP (DEFAULT_HP)
        ) u_ch (
            .clk      (clk),
            .resetnn  (resetnn),
            .i_tick   (r_tick),
            .i_en     (bus.en[n]),
            .i_mode   (bus.mode[n]),
            .i_code   (bus.code[n*CODE_W +: CODE_W]),
            .o_dco    (w_dco[n]),
            .o_toggle (w_toggle[n])
        );
    end

    assign bus.dco_out  = w_dco;
    assign bus.toggle_p = w_toggle;
    assign bus.tick     = r_tick;

endmodule
